// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_pkg : shared FSM state type, segment codes and pow10 helper     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_t;

  // Active-low segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_nibble_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_nibble_dec : nibble to active-low seven-segment decoder (>9 blank)  |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module seg7_nibble_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_display : binary->BCD (double dabble) with multiplexed 7-seg    |
// |                    scanning. Define SEG_SCAN_LZB_EN for leading-zero     |
// |                    blanking.                                             |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                slw_clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [N_DIGITS-1:0] an_cntrl,
  output logic [6:0]          seg_cntrl
);

  localparam int          BCD_W     = 4 * N_DIGITS;
  localparam int          SCAN_W    = $clog2(N_DIGITS);
  localparam int          CNT_W     = $clog2(BIN_W + 1);
  localparam int unsigned OVF_LIMIT = pow10(N_DIGITS) - 32'd1;

  scan_state_t       r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  r_disp;
  logic [CNT_W-1:0]  r_cnt;
  logic [SCAN_W-1:0] r_scan;
  logic              r_ovf_next;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;

  logic [31:0]         w_bin_ext;
  logic [BCD_W-1:0]    w_adj;
  logic [3:0]          w_nibble;
  logic [N_DIGITS-1:0] w_an;

  assign w_bin_ext = {{(32 - BIN_W){1'b0}}, bin};

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_disp     <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_bin      <= bin;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= (w_bin_ext > OVF_LIMIT);
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_disp  <= r_ovf_next ? {N_DIGITS{4'h9}} : r_bcd;
          r_ovf   <= r_ovf_next;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running scan pointer, independent of the conversion FSM
  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
    end else if (r_scan == SCAN_W'(N_DIGITS - 1)) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  always_comb begin
    w_nibble = 4'd0;
    w_an     = '1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_scan == SCAN_W'(d)) begin
        w_nibble = r_disp[4*d +: 4];
        w_an[d]  = 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [SCAN_W-1:0] w_msd;

  // Highest nonzero digit; slots above it are dark, digit 0 always lit
  always_comb begin
    w_msd = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_disp[4*d +: 4] != 4'd0) begin
        w_msd = SCAN_W'(d);
      end
    end
  end

  assign an_cntrl = (r_scan > w_msd) ? '1 : w_an;
`else
  assign an_cntrl = w_an;
`endif

  seg7_nibble_dec u_dec (
    .i_nibble (w_nibble),
    .o_seg    (seg_cntrl)
  );

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed seven-segment digits (2..8).
REQ-002 SHALL have parameter BIN_W, default 14, width of the binary input value (4..27).
REQ-003 SHALL have port slw_clk input 1: scan and conversion clock.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port bin input BIN_W: unsigned binary value to display.
REQ-006 SHALL have port load input 1: single-cycle strobe that captures bin.
REQ-007 SHALL have port busy output 1: conversion in progress.
REQ-008 SHALL have port done output 1: one-cycle pulse when the new value is committed to the display.
REQ-009 SHALL have port ovf output 1: last loaded value exceeded 10^N_DIGITS-1.
REQ-010 SHALL have port an_cntrl output N_DIGITS: active-low anode enables, with bit 0 as the least significant digit.
REQ-011 SHALL have port seg_cntrl output 7: active-low segments (gfedcba).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and COMMIT, and SHALL drive busy=1 in SHIFT and COMMIT.
REQ-013 In IDLE, load=1 at edge k SHALL capture bin, set ovf_next=(bin>10^N_DIGITS-1), clear the BCD accumulator, and move to SHIFT.
REQ-014 SHIFT SHALL perform one double-dabble iteration per edge (add 3 to each nibble >=5, then shift left 1) for exactly BIN_W edges, then move to COMMIT.
REQ-015 COMMIT at edge k+BIN_W+1 SHALL copy the accumulator into the display register, or all nibbles 9 if ovf_next, update ovf, pulse done for one cycle, and return to IDLE.
REQ-016 load asserted while busy=1 SHALL be ignored; the in-flight conversion SHALL be unaffected.
REQ-017 The display register SHALL change only in COMMIT, so scanning never shows a partial conversion.
REQ-018 The scan index SHALL increment every slw_clk edge from 0 to N_DIGITS-1 and wrap to 0, independent of FSM state.
REQ-019 For scan index i, an_cntrl SHALL be all ones except bit i=0, and seg_cntrl SHALL show the decoded nibble i of the display register.
REQ-020 Nibble values 0-9 SHALL decode to standard digits, and any value >9 SHALL drive seg_cntrl=7'b1111111.
REQ-021 an_cntrl and seg_cntrl SHALL be combinational from the scan index and display register, with no added latency.

Reset
REQ-022 rst SHALL force IDLE, scan index 0, accumulator 0, display register 0, busy=0, done=0 and ovf=0.
REQ-023 While rst is held, an_cntrl SHALL be ~1 (bit 0 low) and seg_cntrl SHALL show "0".
REQ-024 rst during SHIFT or COMMIT SHALL abort the conversion without a done pulse.

Configuration
REQ-025 When macro SEG_SCAN_LZB_EN is defined, leading-zero blanking SHALL be compiled in.
REQ-026 With SEG_SCAN_LZB_EN, a slot above the most significant nonzero nibble SHALL drive an_cntrl=all ones; digit 0 SHALL never be blanked.
REQ-027 Without SEG_SCAN_LZB_EN, all N_DIGITS slots SHALL always be driven, and leading zeros SHALL be shown.

Structure
REQ-028 Package seg_scan_pkg SHALL hold the FSM state enum, the 7-bit segment constants for 0-9 and blank, and function pow10(n) used for the overflow limit.
REQ-029 The decoder SHALL be sub-module seg7_nibble_dec (nibble in, active-low segments out), instantiated once.

Verification
REQ-030 N_DIGITS=4, BIN_W=14, load bin=1234 -> done at edge 15 after load; scanning shows 4,3,2,1 with an_cntrl 1110,1101,1011,0111; ovf=0.
REQ-031 load bin=12000 -> after COMMIT, all slots show 9 and ovf=1; a following load bin=5 -> ovf=0.
REQ-032 SEG_SCAN_LZB_EN defined, load bin=7 -> only an_cntrl=1110 is ever active and the other slots drive 1111; without the macro, slots show 0007.
REQ-033 load bin=42, then load bin=99 three cycles later -> second load ignored; display shows 0042 and done pulses exactly once.
REQ-034 rst pulsed at edge 5 of SHIFT after load bin=8888 -> busy=0, no done pulse, display 0000, scan index 0.
REQ-035 N_DIGITS=6, BIN_W=20, load bin=999999 -> scan wraps after index 5 and shows 999999 with ovf=0; bin=1000000 -> ovf=1.
